uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_pkg.sv | 26 ++
 rtl/rr_picker.sv | 33 +++
 rtl/uart_tx.sv | 71 +++++++
 rtl/uart_tx_arb.sv | 189 ++++++++++++++++++
 tb/tb_uart_tx_arb.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg -- shared types and constants for the uart_tx arbiter slice.
//   arb_state_e      : arbiter FSM encoding (ID states only exist when
//                      UART_TX_ARB_ID_PREFIX_EN is defined)
//   ID_HDR_NIBBLE    : upper nibble of the requester-ID header frame
//   DEF_NUM_REQ      : default number of requesters
//   DEF_PAYLOAD_BITS : default frame payload width
package uart_pkg;

    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_PAYLOAD_BITS = 8;

    localparam logic [3:0] ID_HDR_NIBBLE = 4'hA;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_TX   = 3'd1,
        ST_TRIG      = 3'd2,
        ST_WAIT_DONE = 3'd3
`ifdef UART_TX_ARB_ID_PREFIX_EN
        ,
        ST_ID_TRIG   = 3'd4,
        ST_ID_DONE   = 3'd5
`endif
    } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// rr_picker -- combinational round-robin priority picker.
//   req   : request vector
//   ptr   : index where the priority search starts
//   grant : one-hot winner, first set bit at or after ptr (wrapping); zero if no request
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic found_s;
    int   idx_s;

    // Scan from ptr upward with wrap; the first requester found wins.
    always_comb begin
        grant   = '0;
        found_s = 1'b0;
        idx_s   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_s = (int'(ptr) + i) % NUM_REQ;
            if (!found_s && req[idx_s]) begin
                grant[idx_s] = 1'b1;
                found_s      = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx -- 8N1-style serial transmitter (start, PAYLOAD_BITS LSB-first, stop).
//   clk, reset_n : clock, asynchronous active-low reset
//   i_tx_trig    : start a frame (accepted only while not busy)
//   i_data       : payload, sampled with i_tx_trig
//   o_tx         : serial line, idles high
//   o_tx_busy    : high while a frame is on the line
//   o_tx_done    : one-cycle pulse at the end of the stop bit (busy drops with it)
module uart_tx #(
    parameter int CLK_FREQ     = 10_000_000,
    parameter int BIT_RATE     = 115_200,
    parameter int PAYLOAD_BITS = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_tx_trig,
    input  logic [PAYLOAD_BITS-1:0] i_data,
    output logic                    o_tx,
    output logic                    o_tx_busy,
    output logic                    o_tx_done
);

    localparam int CPB        = CLK_FREQ / BIT_RATE;
    localparam int CNT_W      = $clog2(CPB);
    localparam int FRAME_BITS = PAYLOAD_BITS + 2;
    localparam int BIT_W      = $clog2(FRAME_BITS);

    logic [FRAME_BITS-1:0] shreg_r;
    logic [CNT_W-1:0]      clk_cnt_r;
    logic [BIT_W-1:0]      bit_cnt_r;
    logic                  busy_r;
    logic                  done_r;

    // Frame shifter: load on trigger, shift one bit every CPB clocks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg_r   <= '1;
            clk_cnt_r <= '0;
            bit_cnt_r <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (!busy_r) begin
                if (i_tx_trig) begin
                    shreg_r   <= {1'b1, i_data, 1'b0};
                    clk_cnt_r <= '0;
                    bit_cnt_r <= '0;
                    busy_r    <= 1'b1;
                end else begin
                    shreg_r <= '1;
                end
            end else if (clk_cnt_r == CNT_W'(CPB - 1)) begin
                clk_cnt_r <= '0;
                shreg_r   <= {1'b1, shreg_r[FRAME_BITS-1:1]};
                if (bit_cnt_r == BIT_W'(FRAME_BITS - 1)) begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                end else begin
                    bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                end
            end else begin
                clk_cnt_r <= clk_cnt_r + CNT_W'(1);
            end
        end
    end

    assign o_tx      = busy_r ? shreg_r[0] : 1'b1;
    assign o_tx_busy = busy_r;
    assign o_tx_done = done_r;

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb -- round-robin arbiter letting NUM_REQ requesters share one uart_tx.
//   clk, reset_n : clock, asynchronous active-low reset
//   i_req        : per-requester request level
//   i_data       : flattened payloads, requester k at [k*PAYLOAD_BITS +: PAYLOAD_BITS]
//   o_ack        : one-hot, one-cycle pulse when the owner's frame has been sent
//   o_grant      : one-hot current owner, zero when idle
//   o_busy       : high whenever the FSM is outside IDLE
//   o_tx_trig    : to uart_tx i_tx_trig
//   o_tx_data    : to uart_tx i_data
//   i_tx_busy    : from uart_tx o_tx_busy
//   i_tx_done    : from uart_tx o_tx_done
// Optional build macro UART_TX_ARB_ID_PREFIX_EN: each grant first sends a header
// frame {ID_HDR_NIBBLE, owner index} and then the payload frame.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int PAYLOAD_BITS = DEF_PAYLOAD_BITS
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [NUM_REQ-1:0]              i_req,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] i_data,
    output logic [NUM_REQ-1:0]              o_ack,
    output logic [NUM_REQ-1:0]              o_grant,
    output logic                            o_busy,
    output logic                            o_tx_trig,
    output logic [PAYLOAD_BITS-1:0]         o_tx_data,
    input  logic                            i_tx_busy,
    input  logic                            i_tx_done
);

    localparam int PTR_W = $clog2(NUM_REQ);

    arb_state_e                state_r;
    arb_state_e                state_nxt_s;
    logic [PTR_W-1:0]          rr_ptr_r;
    logic [PTR_W-1:0]          ptr_nxt_s;
    logic [PTR_W-1:0]          grant_idx_r;
    logic [NUM_REQ-1:0]        grant_r;
    logic [NUM_REQ-1:0]        ack_r;
    logic                      busy_r;
    logic                      trig_r;
    logic [PAYLOAD_BITS-1:0]   tx_data_r;
    logic [NUM_REQ-1:0]        pick_s;
    logic [PTR_W-1:0]          pick_idx_s;
    logic [PAYLOAD_BITS-1:0]   pick_data_s;
    logic                      trig_nxt_s;
`ifdef UART_TX_ARB_ID_PREFIX_EN
    logic [PAYLOAD_BITS-1:0]   payload_r;
    logic                      hdr_sent_r;
    logic [7:0]                hdr_byte_s;
`endif

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req   (i_req),
        .ptr   (rr_ptr_r),
        .grant (pick_s)
    );

    // Winner index and its payload slice, taken from the one-hot pick.
    always_comb begin
        pick_idx_s  = '0;
        pick_data_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick_s[k]) begin
                pick_idx_s  = PTR_W'(k);
                pick_data_s = i_data[k*PAYLOAD_BITS +: PAYLOAD_BITS];
            end else begin
                pick_idx_s = pick_idx_s;
            end
        end
    end

`ifdef UART_TX_ARB_ID_PREFIX_EN
    // Header frame announcing which requester owns the following payload.
    always_comb begin
        hdr_byte_s = {ID_HDR_NIBBLE, 4'(pick_idx_s)};
    end
`endif

    // Pointer moves just past the owner so it cannot win twice while others wait.
    always_comb begin
        if (grant_idx_r == PTR_W'(NUM_REQ - 1)) begin
            ptr_nxt_s = '0;
        end else begin
            ptr_nxt_s = grant_idx_r + PTR_W'(1);
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (|i_req) state_nxt_s = ST_WAIT_TX;
                else        state_nxt_s = ST_IDLE;
            end
            ST_WAIT_TX: begin
                if (!i_tx_busy) begin
`ifdef UART_TX_ARB_ID_PREFIX_EN
                    state_nxt_s = hdr_sent_r ? ST_TRIG : ST_ID_TRIG;
`else
                    state_nxt_s = ST_TRIG;
`endif
                end else begin
                    state_nxt_s = ST_WAIT_TX;
                end
            end
            ST_TRIG: state_nxt_s = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (i_tx_done) state_nxt_s = ST_IDLE;
                else           state_nxt_s = ST_WAIT_DONE;
            end
`ifdef UART_TX_ARB_ID_PREFIX_EN
            ST_ID_TRIG: state_nxt_s = ST_ID_DONE;
            ST_ID_DONE: begin
                if (i_tx_done) state_nxt_s = ST_WAIT_TX;
                else           state_nxt_s = ST_ID_DONE;
            end
`endif
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Trigger is registered from the next state so it is high exactly while in a TRIG state.
    always_comb begin
`ifdef UART_TX_ARB_ID_PREFIX_EN
        trig_nxt_s = (state_nxt_s == ST_TRIG) || (state_nxt_s == ST_ID_TRIG);
`else
        trig_nxt_s = (state_nxt_s == ST_TRIG);
`endif
    end

    // State register, ownership bookkeeping and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            rr_ptr_r    <= '0;
            grant_idx_r <= '0;
            grant_r     <= '0;
            ack_r       <= '0;
            busy_r      <= 1'b0;
            trig_r      <= 1'b0;
            tx_data_r   <= '0;
`ifdef UART_TX_ARB_ID_PREFIX_EN
            payload_r   <= '0;
            hdr_sent_r  <= 1'b0;
`endif
        end else begin
            state_r <= state_nxt_s;
            trig_r  <= trig_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            ack_r   <= '0;
            if ((state_r == ST_IDLE) && (|i_req)) begin
                grant_r     <= pick_s;
                grant_idx_r <= pick_idx_s;
`ifdef UART_TX_ARB_ID_PREFIX_EN
                payload_r   <= pick_data_s;
                tx_data_r   <= PAYLOAD_BITS'(hdr_byte_s);
                hdr_sent_r  <= 1'b0;
`else
                tx_data_r   <= pick_data_s;
`endif
            end else if ((state_r == ST_WAIT_DONE) && i_tx_done) begin
                ack_r    <= grant_r;
                grant_r  <= '0;
                rr_ptr_r <= ptr_nxt_s;
`ifdef UART_TX_ARB_ID_PREFIX_EN
            end else if ((state_r == ST_ID_DONE) && i_tx_done) begin
                tx_data_r  <= payload_r;
                hdr_sent_r <= 1'b1;
`endif
            end else begin
                grant_r <= grant_r;
            end
        end
    end

    assign o_grant   = grant_r;
    assign o_ack     = ack_r;
    assign o_busy    = busy_r;
    assign o_tx_trig = trig_r;
    assign o_tx_data = tx_data_r;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb -- uart_tx_arb driving a real uart_tx (10 MHz, 115200 baud).
// Stimulus pushes expected serial bytes and ack indices into queues; a serial
// decoder and an ack monitor pop and compare independently.
module tb_uart_tx_arb;

    localparam int NR   = 4;
    localparam int PB   = 8;
    localparam int CLKF = 10_000_000;
    localparam int BAUD = 115_200;
    localparam int CPB  = CLKF / BAUD;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [NR-1:0]   i_req;
    logic [NR*PB-1:0] i_data;
    logic [NR-1:0]   o_ack;
    logic [NR-1:0]   o_grant;
    logic            o_busy;
    logic            tx_trig;
    logic [PB-1:0]   tx_data;
    logic            tx_busy;
    logic            tx_done;
    logic            tx_line;

    int n_checks = 0;
    int n_pass   = 0;
    int ack_seen = 0;
    logic ignore_rx = 1'b0;

    logic [7:0] exp_byte[$];
    int         exp_ack[$];

    always #50 clk = ~clk;

    uart_tx_arb #(.NUM_REQ(NR), .PAYLOAD_BITS(PB)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_req     (i_req),
        .i_data    (i_data),
        .o_ack     (o_ack),
        .o_grant   (o_grant),
        .o_busy    (o_busy),
        .o_tx_trig (tx_trig),
        .o_tx_data (tx_data),
        .i_tx_busy (tx_busy),
        .i_tx_done (tx_done)
    );

    uart_tx #(.CLK_FREQ(CLKF), .BIT_RATE(BAUD), .PAYLOAD_BITS(PB)) u_uart (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_tx_trig (tx_trig),
        .i_data    (tx_data),
        .o_tx      (tx_line),
        .o_tx_busy (tx_busy),
        .o_tx_done (tx_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic expect_frame(input int idx, input logic [7:0] b);
        logic [7:0] hdr;
        hdr = {4'hA, 4'(idx)};
`ifdef UART_TX_ARB_ID_PREFIX_EN
        exp_byte.push_back(hdr);
`endif
        exp_byte.push_back(b);
        exp_ack.push_back(idx);
    endtask

    task automatic set_data(input int k, input logic [7:0] b);
        i_data[k*PB +: PB] = b;
    endtask

    task automatic wait_new_grant(input int budget, output logic [NR-1:0] g);
        int t;
        t = 0;
        while (o_grant !== '0 && t < budget) begin @(negedge clk); t++; end
        while (o_grant === '0 && t < budget) begin @(negedge clk); t++; end
        if (t >= budget) fail_now("grant_timeout");
        g = o_grant;
    endtask

    task automatic wait_idle(input int budget);
        int t;
        t = 0;
        while ((o_busy !== 1'b0 || exp_byte.size() != 0 || exp_ack.size() != 0) && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (t >= budget) fail_now("idle_timeout");
        repeat (2) @(negedge clk);
    endtask

    // Serial decoder: mid-bit sampling of each frame, compared with the byte queue.
    initial begin : rx_mon
        logic [7:0] rx;
        logic       stop;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (tx_line === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int b = 0; b < 8; b++) begin
                    repeat (CPB) @(negedge clk);
                    rx[b] = tx_line;
                end
                repeat (CPB) @(negedge clk);
                stop = tx_line;
                if (!ignore_rx) begin
                    if (exp_byte.size() == 0) begin
                        check("rx_unexpected", {23'd0, stop, rx}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_byte.pop_front();
                        check("rx_byte", {23'd0, stop, rx}, {23'd0, 1'b1, e});
                    end
                end
            end
        end
    end

    // Ack monitor: every o_ack pulse must match the next queued owner.
    initial begin : ack_mon
        int e;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && o_ack !== '0) begin
                ack_seen++;
                if (exp_ack.size() == 0) begin
                    check("ack_unexpected", {28'd0, o_ack}, 32'd0);
                end else begin
                    e = exp_ack.pop_front();
                    check("ack", {28'd0, o_ack}, 32'd1 << e);
                end
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin : watchdog
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [NR-1:0] g;
        int            ord[5];
        logic [7:0]    dat[4];
        int            acks_before;
        ord = '{0, 1, 2, 3, 0};
        dat = '{8'h11, 8'h22, 8'h33, 8'h44};

        reset_n = 1'b0;
        i_req   = '0;
        i_data  = '0;
        repeat (3) @(negedge clk);
        check("rst_grant", {28'd0, o_grant}, 32'd0);
        check("rst_ack",   {28'd0, o_ack},   32'd0);
        check("rst_busy",  {31'd0, o_busy},  32'd0);
        check("rst_trig",  {31'd0, tx_trig}, 32'd0);
        check("rst_data",  {24'd0, tx_data}, 32'd0);
        check("rst_line",  {31'd0, tx_line}, 32'd1);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_no_req_busy", {31'd0, o_busy}, 32'd0);

        // Single request: grant, latched data, trigger in cycle 2, one-cycle pulse.
        set_data(0, 8'h55);
        i_req = 4'b0001;
        expect_frame(0, 8'h55);
        @(negedge clk);
        check("t1_grant", {28'd0, o_grant}, 32'd1);
        check("t1_busy",  {31'd0, o_busy},  32'd1);
        check("t1_trig_c1", {31'd0, tx_trig}, 32'd0);
`ifdef UART_TX_ARB_ID_PREFIX_EN
        check("t1_data", {24'd0, tx_data}, 32'hA0);
`else
        check("t1_data", {24'd0, tx_data}, 32'h55);
`endif
        i_req = '0;
        @(negedge clk);
        check("t1_trig_c2", {31'd0, tx_trig}, 32'd1);
        @(negedge clk);
        check("t1_trig_c3", {31'd0, tx_trig}, 32'd0);
        wait_idle(5000);
        check("t1_idle_grant", {28'd0, o_grant}, 32'd0);

        // Restart from rr_ptr=0 for the all-requesters sweep.
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // All four request continuously: 0,1,2,3 then 0 again.
        for (int k = 0; k < 4; k++) set_data(k, dat[k]);
        for (int n = 0; n < 5; n++) expect_frame(ord[n], dat[ord[n]]);
        i_req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_new_grant(4000, g);
            check("t2_grant", {28'd0, g}, 32'd1 << ord[n]);
        end
        i_req = '0;
        wait_idle(5000);

        // Fairness: requester 2 holds, requester 0 requests once (ptr is 1 here).
        set_data(2, 8'hC3);
        set_data(0, 8'h3C);
        expect_frame(2, 8'hC3);
        expect_frame(0, 8'h3C);
        expect_frame(2, 8'hC3);
        i_req = 4'b0101;
        wait_new_grant(4000, g);
        check("t3_grant_a", {28'd0, g}, 32'h4);
        wait_new_grant(4000, g);
        check("t3_grant_b", {28'd0, g}, 32'h1);
        i_req = 4'b0100;
        wait_new_grant(4000, g);
        check("t3_grant_c", {28'd0, g}, 32'h4);
        i_req = '0;
        wait_idle(5000);

        // Withdrawn request: payload already latched must still go out.
        set_data(1, 8'hA5);
        expect_frame(1, 8'hA5);
        i_req = 4'b0010;
        wait_new_grant(4000, g);
        check("t4_grant", {28'd0, g}, 32'h2);
        i_req = '0;
        set_data(1, 8'hFF);
        wait_idle(5000);

        // Reset mid-frame: frame abandoned, no ack, pointer back to 0.
        set_data(3, 8'h96);
        i_req = 4'b1000;
        wait_new_grant(4000, g);
        check("t5_grant", {28'd0, g}, 32'h8);
        i_req = '0;
        repeat (300) @(negedge clk);
        check("t5_busy_mid", {31'd0, o_busy}, 32'd1);
        ignore_rx   = 1'b1;
        acks_before = ack_seen;
        reset_n     = 1'b0;
        #1;
        check("t5_rst_grant", {28'd0, o_grant}, 32'd0);
        check("t5_rst_busy",  {31'd0, o_busy},  32'd0);
        check("t5_rst_ack",   {28'd0, o_ack},   32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (1000) @(negedge clk);
        check("t5_no_ack", ack_seen, acks_before);
        ignore_rx = 1'b0;
        set_data(1, 8'h81);
        set_data(3, 8'h69);
        expect_frame(1, 8'h81);
        i_req = 4'b1010;
        wait_new_grant(4000, g);
        check("t5_ptr0_grant", {28'd0, g}, 32'h2);
        i_req = '0;
        wait_idle(5000);

        // Requester 3 with 0x5A (header 0xA3 first when the prefix is built in).
        set_data(3, 8'h5A);
        expect_frame(3, 8'h5A);
        i_req = 4'b1000;
        wait_new_grant(4000, g);
        check("t6_grant", {28'd0, g}, 32'h8);
        i_req = '0;
        wait_idle(5000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
